in_port_conditioner: RTL and testbench
======================================

// Module: in_port_conditioner
// PURPOSE
//  Conditions the 8 raw, asynchronous GPIO input pins before they reach the memory-mapped input reader.
//  - Synchronises each pin into the clk domain and debounces it per bit.
//  - Drives the stable byte that the bus reader returns at address 4.
//  - Generates per-bit rise/fall pulses and a sticky change interrupt for the core.
// PARAMETERS
//  WIDTH            8      number of input pins
//  SYNC_STAGES      2      synchroniser depth, >=2
//  DEBOUNCE_CYCLES  16     consecutive cycles a new level must hold before it is accepted, >=1
//  RESET_VALUE      8'h00  value of synchroniser flops and io_port after reset
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      synchronous active-low reset
//  pins_in      in   WIDTH  raw asynchronous pin levels
//  io_port      out  WIDTH  debounced stable levels, feeds bus input reader
//  rise         out  WIDTH  1-cycle pulse per bit on accepted 0->1
//  fall         out  WIDTH  1-cycle pulse per bit on accepted 1->0
//  irq_mask     in   WIDTH  per-bit enable for interrupt capture
//  irq_clear    in   1      1-cycle pulse, clears edge_flags and irq
//  edge_flags   out  WIDTH  sticky per-bit "masked edge seen"
//  irq          out  1      OR of edge_flags
// BEHAVIOUR
//  - One clock, clk; reset is synchronous, active-low (rst_n); all state updates on posedge clk only.
//  - Reset values:
//    - sync chain and io_port = RESET_VALUE.
//    - Debounce counters = 0.
//    - rise, fall, edge_flags, irq = 0.
//    - No edges are reported on reset exit.
//  - Synchroniser: SYNC_STAGES flops per bit; s[i] = last stage. Nothing else samples pins_in.
//  - Debounce, per bit i, counter width max(1,$clog2(DEBOUNCE_CYCLES)):
//    - If s[i]==io_port[i]: cnt<=0.
//    - Else if cnt==DEBOUNCE_CYCLES-1: io_port[i]<=s[i], cnt<=0.
//    - Else cnt<=cnt+1.
//    - A glitch shorter than DEBOUNCE_CYCLES restarts the count and is never reported.
//    - DEBOUNCE_CYCLES=1 means accept on the first differing cycle.
//  - Latency: a pin change held steady appears on io_port SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples it.
//  - rise/fall:
//    - Registered together with the io_port update, high exactly in the first cycle io_port shows the new value.
//    - Never both high on one bit.
//    - Bits update independently; several may pulse in the same cycle.
//  - Counters saturate by construction (reset on accept); no wrap-around.
//  - Reset mid-count discards the pending level; counting restarts from the RESET_VALUE baseline.
// CONFIGURATION
//  - Macro IN_PORT_COND_IRQ_EN.
//  - Defined:
//    - edge_flags[i] <= (edge_flags[i] & ~irq_clear) | ((rise[i]|fall[i]) & irq_mask[i]).
//    - A new edge in the same cycle as irq_clear wins (flag stays set).
//    - irq = |edge_flags, registered with edge_flags.
//  - Not defined:
//    - No edge_flags/irq logic is synthesised; edge_flags=0, irq=0 constantly.
//    - irq_mask and irq_clear are ignored.
//    - rise/fall remain.
// TESTING  (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0)
//  - rst_n=0 for 2 cycles with pins_in=8'hFF, release:
//    - io_port=0, rise=0 during reset.
//    - Then io_port=8'hFF 6 edges after release.
//    - rise=8'hFF for exactly that one cycle.
//  - From idle, pins_in[3] 0->1 held:
//    - io_port[3]=1 at edge 6 after change.
//    - rise[3] pulses 1 cycle.
//    - All other outputs unchanged.
//  - pins_in[0] high 3 cycles then low -> io_port[0], rise[0], fall[0] stay 0 throughout.
//  - pins_in 8'h00->8'h81 simultaneously -> rise=8'h81 in a single cycle, io_port=8'h81.
//  - IRQ_EN defined, irq_mask=8'h01, bit1 and bit0 rise:
//    - edge_flags=8'h01, irq=1.
//    - irq_clear pulse -> both 0 next cycle.
//    - irq_clear coinciding with a new bit0 rise -> edge_flags stays 8'h01.
//  - IRQ_EN undefined, same stimulus -> irq=0, edge_flags=0, rise still 8'h03.

Source files
------------

// File: rtl/in_port_conditioner.sv
// GPIO input conditioner: per-bit synchroniser, debounce, rise/fall pulses and an
// optional sticky masked-edge interrupt, compiled in by defining IN_PORT_COND_IRQ_EN.
module in_port_conditioner #(
   parameter int               WIDTH           = 8,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] io_port,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic             irq_clear,
   output logic [WIDTH-1:0] edge_flags,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;

   logic [WIDTH-1:0] io_port_q, io_port_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;

   // Only the first stage ever touches the raw pins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RESET_VALUE;
         end
      end else begin
         sync_q[0] <= pins_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Any cycle where the synchronised level matches the accepted one restarts the count.
         always_comb begin
            cnt_d         = cnt_q;
            io_port_d[gi] = io_port_q[gi];
            rise_d[gi]    = 1'b0;
            fall_d[gi]    = 1'b0;
            if (sync_s[gi] == io_port_q[gi]) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d         = '0;
               io_port_d[gi] = sync_s[gi];
               rise_d[gi]    = sync_s[gi];
               fall_d[gi]    = ~sync_s[gi];
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         io_port_q <= RESET_VALUE;
         rise_q    <= '0;
         fall_q    <= '0;
      end else begin
         io_port_q <= io_port_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign io_port = io_port_q;
   assign rise    = rise_q;
   assign fall    = fall_q;

`ifdef IN_PORT_COND_IRQ_EN
   logic [WIDTH-1:0] edge_flags_q, edge_flags_d;
   logic             irq_q;

   // A masked edge arriving with irq_clear keeps its flag set.
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_flag
         assign edge_flags_d[gi] = (edge_flags_q[gi] & ~irq_clear)
                                 | ((rise_q[gi] | fall_q[gi]) & irq_mask[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         edge_flags_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         edge_flags_q <= edge_flags_d;
         irq_q        <= |edge_flags_d;
      end
   end

   assign edge_flags = edge_flags_q;
   assign irq        = irq_q;
`else
   logic unused_irq_inputs;

   assign unused_irq_inputs = ^{irq_mask, irq_clear};
   assign edge_flags        = '0;
   assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_conditioner.sv
// Self-checking bench for in_port_conditioner: directed scenarios then random pin
// activity, every cycle compared against a run-length reference model.
module tb_in_port_conditioner;

   localparam int         W  = 8;
   localparam int         S  = 2;
   localparam int         D  = 4;
   localparam logic [7:0] RV = 8'h00;
`ifdef IN_PORT_COND_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] pins_in;
   logic [W-1:0] io_port;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic [W-1:0] irq_mask;
   logic         irq_clear;
   logic [W-1:0] edge_flags;
   logic         irq;

   always #5 clk = ~clk;

   in_port_conditioner #(
      .WIDTH          (W),
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .RESET_VALUE    (RV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pins_in   (pins_in),
      .io_port   (io_port),
      .rise      (rise),
      .fall      (fall),
      .irq_mask  (irq_mask),
      .irq_clear (irq_clear),
      .edge_flags(edge_flags),
      .irq       (irq)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cycle   = 0;

   // Reference model: pin samples seen S edges ago, plus per-bit run length of
   // consecutive differing samples against the accepted level.
   logic [W-1:0] m_hist[$];
   logic [W-1:0] m_io    = RV;
   logic [W-1:0] m_rise  = '0;
   logic [W-1:0] m_fall  = '0;
   logic [W-1:0] m_flags = '0;
   logic         m_irq   = 1'b0;
   int           m_run[W];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
   endtask

   task automatic model_edge();
      logic [W-1:0] s;
      logic [W-1:0] nr;
      logic [W-1:0] nf;
      if (!rst_n) begin
         m_hist = {};
         for (int k = 0; k < S; k++) m_hist.push_back(RV);
         m_io    = RV;
         m_rise  = '0;
         m_fall  = '0;
         m_flags = '0;
         m_irq   = 1'b0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         return;
      end
      s = m_hist.pop_front();
      m_hist.push_back(pins_in);
      if (IRQ_EN) begin
         m_flags = (m_flags & ~{W{irq_clear}}) | ((m_rise | m_fall) & irq_mask);
         m_irq   = |m_flags;
      end
      nr = '0;
      nf = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] != m_io[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_io[i]  = s[i];
               nr[i]    = s[i];
               nf[i]    = ~s[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_rise = nr;
      m_fall = nf;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cycle++;
      @(negedge clk);
      chk("io_port", 32'(io_port), 32'(m_io));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("rise_fall_excl", 32'(rise & fall), 32'h0);
      chk("edge_flags", 32'(edge_flags), 32'(m_flags));
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int hold;
      rst_n     = 1'b0;
      pins_in   = 8'hFF;
      irq_mask  = 8'h00;
      irq_clear = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      @(negedge clk);

      // Reset with pins high, release, accepted on the 6th edge.
      steps(2);
      chk("reset_io", 32'(io_port), 32'h00);
      chk("reset_rise", 32'(rise), 32'h00);
      rst_n = 1'b1;
      steps(5);
      chk("release_io_early", 32'(io_port), 32'h00);
      step();
      chk("release_io", 32'(io_port), 32'hFF);
      chk("release_rise", 32'(rise), 32'hFF);
      step();
      chk("release_rise_once", 32'(rise), 32'h00);

      pins_in = 8'h00;
      steps(10);
      chk("idle_io", 32'(io_port), 32'h00);

      // Single bit rise.
      pins_in = 8'h08;
      steps(5);
      chk("bit3_early", 32'(io_port), 32'h00);
      step();
      chk("bit3_io", 32'(io_port), 32'h08);
      chk("bit3_rise", 32'(rise), 32'h08);
      step();
      chk("bit3_rise_once", 32'(rise), 32'h00);
      pins_in = 8'h00;
      steps(10);

      // Glitch shorter than the debounce window.
      pins_in = 8'h01;
      steps(3);
      pins_in = 8'h00;
      steps(10);
      chk("glitch_io", 32'(io_port), 32'h00);

      // Simultaneous multi-bit rise.
      pins_in = 8'h81;
      steps(6);
      chk("multi_rise", 32'(rise), 32'h81);
      chk("multi_io", 32'(io_port), 32'h81);
      pins_in = 8'h00;
      steps(10);

      // Masked interrupt capture and clear.
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      irq_mask  = 8'h01;
      pins_in   = 8'h03;
      steps(6);
      chk("irq_rise", 32'(rise), 32'h03);
      step();
      chk("irq_flags", 32'(edge_flags), IRQ_EN ? 32'h01 : 32'h00);
      chk("irq_level", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("irq_cleared", 32'(edge_flags), 32'h00);
      chk("irq_cleared_level", 32'(irq), 32'h0);
      pins_in = 8'h00;
      steps(8);
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      pins_in   = 8'h01;
      steps(6);
      chk("coincide_rise", 32'(rise), 32'h01);
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("coincide_flags", 32'(edge_flags), IRQ_EN ? 32'h01 : 32'h00);
      chk("coincide_irq", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);

      // Reset in the middle of a pending count.
      pins_in = 8'hF0;
      steps(3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      steps(8);

      // Random pin activity with mixed hold times, masks and clears.
      for (int n = 0; n < 400; n++) begin
         pins_in  = 8'($urandom);
         irq_mask = 8'($urandom);
         hold     = int'($urandom_range(1, 8));
         for (int k = 0; k < hold; k++) begin
            irq_clear = ($urandom_range(0, 7) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
         end
      end
      rst_n     = 1'b1;
      irq_clear = 1'b0;
      steps(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
